// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared types and helpers for the 2048 datapath.
//                - Board geometry constants (tile width, box count, score
//                  accumulator width).
//                - Swipe direction and move-stage FSM state enums.
//                - Helpers that map a box index, or a (direction, line,
//                  element) triple, to a nibble position in the packed board.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int TILE_W   = 4;
    localparam int N_BOXES  = 16;
    localparam int SCORE_W  = 19;
    localparam int LINE_LEN = 4;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LINE = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Box 0 (top-left) lives in the most significant nibble.
    function automatic int box_lsb(input int box);
        return (N_BOXES - 1 - box) * TILE_W;
    endfunction

    // Zero-based box index of element e of line k; element 0 is the head,
    // i.e. the box nearest the wall the tiles slide toward.
    function automatic int line_box(input dir_e d, input int k, input int e);
        case (d)
            DIR_LEFT:  return 4 * k + e;
            DIR_RIGHT: return 4 * k + (3 - e);
            DIR_UP:    return k + 4 * e;
            default:   return k + 4 * (3 - e);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_compact.sv
`default_nettype none
// ============================================================================
//  Module      : line_compact
//  Description : Combinational slide-and-merge of one 4-tile line.
//                Element 0 (bits [3:0]) is the head of the line.
//                Nonzero tiles are compacted toward the head, equal neighbours
//                merge once scanning from the head (saturating at TILE_MAX),
//                and the tail is zero-filled.
//  Ports       : line_in    [15:0] input line, element e at [4e+3:4e]
//                line_out   [15:0] processed line, same packing
//                score      [16:0] sum of 2^result over merges in this line
//                max_merged [3:0]  largest merged value (WIN_DETECT_EN only)
//  Config      : WIN_DETECT_EN adds the max_merged output.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_compact #(
    parameter int TILE_MAX = 15
) (
    input  logic [15:0] line_in,
    output logic [15:0] line_out,
    output logic [16:0] score
`ifdef WIN_DETECT_EN
    ,
    output logic [3:0]  max_merged
`endif
);

    logic [3:0] w_cmp [5];   // compacted line; entry 4 stays empty as a sentinel
    logic [3:0] w_res;
    logic       w_skip;
    int         w_n;
    int         w_j;
`ifdef WIN_DETECT_EN
    logic [3:0] w_max;
`endif

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            w_cmp[i] = 4'd0;
        end
        line_out = 16'd0;
        score    = 17'd0;
        w_res    = 4'd0;
        w_skip   = 1'b0;
        w_n      = 0;
        w_j      = 0;
`ifdef WIN_DETECT_EN
        w_max    = 4'd0;
`endif

        for (int e = 0; e < 4; e++) begin
            if (line_in[4*e +: 4] != 4'd0) begin
                w_cmp[w_n] = line_in[4*e +: 4];
                w_n        = w_n + 1;
            end
        end

        // The sentinel zero in w_cmp[4] prevents the last tile from pairing.
        for (int i = 0; i < 4; i++) begin
            if (w_skip) begin
                w_skip = 1'b0;
            end else if (w_cmp[i] != 4'd0) begin
                if (w_cmp[i + 1] == w_cmp[i]) begin
                    if (w_cmp[i] >= 4'(TILE_MAX)) begin
                        w_res = 4'(TILE_MAX);
                    end else begin
                        w_res = w_cmp[i] + 4'd1;
                    end
                    score  = score + (17'd1 << w_res);
                    w_skip = 1'b1;
`ifdef WIN_DETECT_EN
                    if (w_res > w_max) begin
                        w_max = w_res;
                    end
`endif
                end else begin
                    w_res = w_cmp[i];
                end
                line_out[4*w_j +: 4] = w_res;
                w_j = w_j + 1;
            end
        end
    end

`ifdef WIN_DETECT_EN
    assign max_merged = w_max;
`endif

endmodule
`default_nettype wire

// File: rtl/tile_slide_merge.sv
`default_nettype none
// ============================================================================
//  Module      : tile_slide_merge
//  Description : 2048 move stage. Latches a packed 4x4 board and a direction,
//                processes one line per clock through a shared line_compact,
//                then presents the post-move board, moved flag and score.
//                start at cycle 0, LINE cycles 1-4, done pulse at cycle 5.
//  Ports       : clock, resetn (async active-low)
//                start, dir[1:0], board_in[63:0]      - move request
//                busy, done                           - status
//                board_out[63:0], moved, score_inc[18:0] - held results
//                win (WIN_DETECT_EN only)             - held with results
//  Config      : macro WIN_DETECT_EN adds the win output and its tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_slide_merge
    import game_pkg::*;
#(
    parameter int WIN_LOG2 = 11,
    parameter int TILE_MAX = 15
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic [1:0]   dir,
    input  logic [63:0]  board_in,
    output logic         busy,
    output logic         done,
    output logic [63:0]  board_out,
    output logic         moved,
    output logic [18:0]  score_inc
`ifdef WIN_DETECT_EN
    ,
    output logic         win
`endif
);

    state_e               r_state;
    logic [1:0]           r_k;
    dir_e                 r_dir;
    logic [63:0]          r_work;
    logic [63:0]          r_orig;
    logic [SCORE_W-1:0]   r_acc;

    logic [15:0]          w_line_in;
    logic [15:0]          w_line_out;
    logic [16:0]          w_line_score;
    logic [63:0]          w_next_work;
    logic [SCORE_W-1:0]   w_acc_next;

    // Gather the current line and scatter its result back to the same boxes.
    always_comb begin
        w_line_in   = 16'd0;
        w_next_work = r_work;
        for (int e = 0; e < LINE_LEN; e++) begin
            w_line_in[e*TILE_W +: TILE_W] =
                r_work[box_lsb(line_box(r_dir, int'(r_k), e)) +: TILE_W];
            w_next_work[box_lsb(line_box(r_dir, int'(r_k), e)) +: TILE_W] =
                w_line_out[e*TILE_W +: TILE_W];
        end
    end

    assign w_acc_next = r_acc + SCORE_W'(w_line_score);

`ifdef WIN_DETECT_EN
    logic [3:0] w_max_merged;
    logic       w_line_win;
    logic       r_win_acc;

    line_compact #(
        .TILE_MAX   (TILE_MAX)
    ) u_line (
        .line_in    (w_line_in),
        .line_out   (w_line_out),
        .score      (w_line_score),
        .max_merged (w_max_merged)
    );

    // A zero max means no merge happened on this line.
    assign w_line_win = (w_max_merged != 4'd0) && (int'({28'd0, w_max_merged}) >= WIN_LOG2);
`else
    line_compact #(
        .TILE_MAX   (TILE_MAX)
    ) u_line (
        .line_in    (w_line_in),
        .line_out   (w_line_out),
        .score      (w_line_score)
    );
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_k       <= 2'd0;
            r_dir     <= DIR_UP;
            r_work    <= 64'd0;
            r_orig    <= 64'd0;
            r_acc     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            board_out <= 64'd0;
            moved     <= 1'b0;
            score_inc <= '0;
`ifdef WIN_DETECT_EN
            r_win_acc <= 1'b0;
            win       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_work  <= board_in;
                        r_orig  <= board_in;
                        r_dir   <= dir_e'(dir);
                        r_acc   <= '0;
                        r_k     <= 2'd0;
                        busy    <= 1'b1;
                        r_state <= ST_LINE;
`ifdef WIN_DETECT_EN
                        r_win_acc <= 1'b0;
`endif
                    end
                end
                ST_LINE: begin
                    r_work <= w_next_work;
                    r_acc  <= w_acc_next;
                    r_k    <= r_k + 2'd1;
`ifdef WIN_DETECT_EN
                    r_win_acc <= r_win_acc | w_line_win;
`endif
                    // Results are registered as the last line completes so that
                    // they are valid in the same cycle as the done pulse.
                    if (r_k == 2'd3) begin
                        r_state   <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        board_out <= w_next_work;
                        moved     <= (w_next_work != r_orig);
                        score_inc <= w_acc_next;
`ifdef WIN_DETECT_EN
                        win       <= r_win_acc | w_line_win;
`endif
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_slide_merge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_slide_merge
//  Description : Self-checking bench for tile_slide_merge. Table of move
//                vectors with hand-derived expected boards, plus sequences for
//                an ignored mid-move start and a reset abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_slide_merge;

    logic         clock = 1'b0;
    logic         resetn;
    logic         start;
    logic [1:0]   dir;
    logic [63:0]  board_in;
    logic         busy;
    logic         done;
    logic [63:0]  board_out;
    logic         moved;
    logic [18:0]  score_inc;
`ifdef WIN_DETECT_EN
    logic         win;
`endif

    always #5 clock = ~clock;

    tile_slide_merge dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .dir       (dir),
        .board_in  (board_in),
        .busy      (busy),
        .done      (done),
        .board_out (board_out),
        .moved     (moved),
        .score_inc (score_inc)
`ifdef WIN_DETECT_EN
        ,
        .win       (win)
`endif
    );

    typedef struct {
        logic [1:0]  dir;
        logic [63:0] board;
        logic [63:0] exp_board;
        logic        exp_moved;
        logic [18:0] exp_score;
        logic        exp_win;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_applied = 0;
    int   n_miss    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] d, input logic [63:0] b,
                                input logic [63:0] e, input logic m,
                                input logic [18:0] s, input logic w);
        vec_t v;
        v.dir = d; v.board = b; v.exp_board = e;
        v.exp_moved = m; v.exp_score = s; v.exp_win = w;
        return v;
    endfunction

    // Drives start for one cycle (cycle 0); returns at the cycle-1 sample point.
    task automatic issue(input vec_t v);
        @(negedge clock);
        dir      = v.dir;
        board_in = v.board;
        start    = 1'b1;
        sb.push_back(v);
        @(negedge clock);
        start    = 1'b0;
        board_in = 64'hDEAD_BEEF_CAFE_F00D;
        dir      = ~v.dir;
    endtask

    // Called at the cycle-1 sample point; waits for done and scores the result.
    task automatic finish_move(input string tag);
        int   lat;
        vec_t v;
        lat = 1;
        chk({tag, " busy_c1"}, 64'(busy), 64'd1);
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk({tag, " done_seen"}, 64'(done), 64'd1);
        if (done === 1'b1) begin
            chk({tag, " latency"}, 64'(lat), 64'd5);
            chk({tag, " busy_done"}, 64'(busy), 64'd0);
            if (sb.size() > 0) begin
                v = sb.pop_front();
                chk({tag, " board"}, board_out, v.exp_board);
                chk({tag, " moved"}, 64'(moved), 64'(v.exp_moved));
                chk({tag, " score"}, 64'(score_inc), 64'(v.exp_score));
`ifdef WIN_DETECT_EN
                chk({tag, " win"}, 64'(win), 64'(v.exp_win));
`endif
                @(negedge clock);
                chk({tag, " done_pulse"}, 64'(done), 64'd0);
                chk({tag, " board_held"}, board_out, v.exp_board);
            end else begin
                chk({tag, " scoreboard_empty"}, 64'(sb.size()), 64'd1);
            end
        end else begin
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   extra_done;
        vec_t va;
        vec_t vb;

        resetn   = 1'b0;
        start    = 1'b0;
        dir      = 2'd0;
        board_in = 64'd0;
        repeat (2) @(negedge clock);
        chk("reset busy",  64'(busy), 64'd0);
        chk("reset done",  64'(done), 64'd0);
        chk("reset moved", 64'(moved), 64'd0);
        chk("reset board", board_out, 64'd0);
        chk("reset score", 64'(score_inc), 64'd0);
        resetn = 1'b1;
        @(negedge clock);

        // dir: 0=up 1=down 2=left 3=right
        vecs.push_back(mk(2'd2, 64'h1120_0000_0000_0000, 64'h2200_0000_0000_0000, 1'b1, 19'd4,     1'b0));
        vecs.push_back(mk(2'd2, 64'h2222_0000_0000_0000, 64'h3300_0000_0000_0000, 1'b1, 19'd16,    1'b0));
        vecs.push_back(mk(2'd3, 64'h1001_0000_0000_0000, 64'h0002_0000_0000_0000, 1'b1, 19'd4,     1'b0));
        vecs.push_back(mk(2'd0, 64'hF000_F000_0000_0000, 64'hF000_0000_0000_0000, 1'b1, 19'd32768, 1'b1));
        vecs.push_back(mk(2'd2, 64'h1234_2341_3412_4123, 64'h1234_2341_3412_4123, 1'b0, 19'd0,     1'b0));
        vecs.push_back(mk(2'd1, 64'h1234_2341_3412_4123, 64'h1234_2341_3412_4123, 1'b0, 19'd0,     1'b0));
        vecs.push_back(mk(2'd1, 64'h0100_0100_0100_0000, 64'h0000_0000_0100_0200, 1'b1, 19'd4,     1'b0));
        vecs.push_back(mk(2'd3, 64'h0000_0000_0000_2233, 64'h0000_0000_0000_0034, 1'b1, 19'd24,    1'b0));
        vecs.push_back(mk(2'd2, 64'h0000_1111_0303_0000, 64'h0000_2200_4000_0000, 1'b1, 19'd24,    1'b0));
        vecs.push_back(mk(2'd0, 64'h0000_0000_0000_5000, 64'h5000_0000_0000_0000, 1'b1, 19'd0,     1'b0));
        vecs.push_back(mk(2'd2, 64'h2110_0000_0000_0000, 64'h2200_0000_0000_0000, 1'b1, 19'd4,     1'b0));
        vecs.push_back(mk(2'd2, 64'h1111_2222_3333_4444, 64'h2200_3300_4400_5500, 1'b1, 19'd120,   1'b0));
        vecs.push_back(mk(2'd3, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 19'd0,     1'b0));
        vecs.push_back(mk(2'd3, 64'hFFF0_0000_0000_0000, 64'h00FF_0000_0000_0000, 1'b1, 19'd32768, 1'b1));
        vecs.push_back(mk(2'd1, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 19'd0,     1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i]);
            finish_move($sformatf("vec%0d", i));
        end

        // A start during LINE (cycle 2) must be ignored, not queued.
        va = mk(2'd2, 64'h1120_0000_0000_0000, 64'h2200_0000_0000_0000, 1'b1, 19'd4, 1'b0);
        issue(va);
        @(negedge clock);               // cycle 2
        start    = 1'b1;
        dir      = 2'd3;
        board_in = 64'h4444_0000_0000_0000;
        @(negedge clock);               // cycle 3
        start    = 1'b0;
        // finish_move counts latency from cycle 1; we are two cycles later.
        begin
            int lat;
            lat = 3;
            while (done !== 1'b1 && lat < 20) begin
                @(negedge clock);
                lat++;
            end
            chk("ignore done_seen", 64'(done), 64'd1);
            if (done === 1'b1) begin
                vb = sb.pop_front();
                chk("ignore latency", 64'(lat), 64'd5);
                chk("ignore board", board_out, vb.exp_board);
                chk("ignore score", 64'(score_inc), 64'(vb.exp_score));
            end else begin
                if (sb.size() > 0) void'(sb.pop_front());
            end
        end
        extra_done = 0;
        repeat (10) begin
            @(negedge clock);
            if (done === 1'b1) extra_done++;
        end
        chk("ignore no_second_done", 64'(extra_done), 64'd0);

        // Reset at cycle 3 aborts the move with no done pulse.
        va = mk(2'd2, 64'h2222_0000_0000_0000, 64'h3300_0000_0000_0000, 1'b1, 19'd16, 1'b0);
        issue(va);
        @(negedge clock);               // cycle 2
        @(negedge clock);               // cycle 3
        resetn = 1'b0;
        #1;
        chk("abort busy",  64'(busy), 64'd0);
        chk("abort done",  64'(done), 64'd0);
        chk("abort moved", 64'(moved), 64'd0);
        chk("abort board", board_out, 64'd0);
        chk("abort score", 64'(score_inc), 64'd0);
`ifdef WIN_DETECT_EN
        chk("abort win",   64'(win), 64'd0);
`endif
        void'(sb.pop_front());
        extra_done = 0;
        repeat (2) begin
            @(negedge clock);
            if (done === 1'b1) extra_done++;
        end
        resetn = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (done === 1'b1) extra_done++;
        end
        chk("abort no_done", 64'(extra_done), 64'd0);

        // Normal move after the abort.
        va = mk(2'd3, 64'h1001_0000_0000_0000, 64'h0002_0000_0000_0000, 1'b1, 19'd4, 1'b0);
        issue(va);
        finish_move("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tile_slide_merge.md
Name: tile_slide_merge

Overview:
- Move stage of the 2048 datapath. It takes the packed 4x4 board and a swipe direction, then slides and merges tiles one line per clock.
- It produces the post-move board, a moved flag and a score increment.
- Its output feeds the tile spawner directly; `moved` is the spawner's enable.

Parameters:
- WIN_LOG2, default 11: log2 tile value treated as a win (11 = 2048). Used only with WIN_DETECT_EN.
- TILE_MAX, default 15: largest encodable log2 tile value. Merges saturate at this value.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a move; accepted only in IDLE.
- dir  in  2  direction, sampled with start: 0=up, 1=down, 2=left, 3=right.
- board_in  in  64  packed board, sampled with start. box1 = [63:60] through box16 = [3:0]; row-major, box1 top-left. Nibble = log2 value, 0 = empty.
- busy  out  1  high from the accept cycle through the LINE cycles.
- done  out  1  one-cycle pulse; board_out, moved and score_inc are valid from this cycle.
- board_out  out  64  post-move board, same packing; held until the next done.
- moved  out  1  1 if board_out != sampled board_in; held with board_out.
- score_inc  out  19  sum of 2^v over every merged tile value v produced by this move; held with board_out.

Behaviour:
- Reset (async, resetn=0):
  - state = IDLE.
  - busy, done, moved = 0; board_out = 0; score_inc = 0; internal line counter = 0.
  - Reset during LINE aborts the move; no done pulse is issued.
- FSM: IDLE -> LINE -> DONE -> IDLE.
  - IDLE: start=1 latches board_in and dir into a working register, clears the score accumulator and line counter, and moves to LINE.
  - LINE: one line per cycle, line index k = 0..3. Exits to DONE after k=3.
  - DONE: loads board_out, moved and score_inc from the working register, pulses done, returns to IDLE.
- Timing: start accepted at cycle 0; LINE occupies cycles 1-4; done at cycle 5. A new start is accepted at cycle 6 at the earliest.
- start while busy or in DONE is ignored; it is not queued.
- Line extraction, with the head listed first (element 0 is nearest the wall moved toward):
  - left: boxes 4k+1..4k+4.
  - right: boxes 4k+4..4k+1.
  - up: boxes k+1, k+5, k+9, k+13.
  - down: boxes k+13, k+9, k+5, k+1.
  - The processed line is written back to the same positions in the working register.
- Line rule:
  - Compact nonzero tiles toward the head, preserving order.
  - Scan from the head and merge each equal adjacent pair once. Result = v+1, saturating at TILE_MAX; two TILE_MAX tiles give TILE_MAX.
  - A merged tile never merges again within the same move.
  - Fill the tail with zeros.
- Score: each merge adds (1 << result), with result after saturation, to a 19-bit accumulator. Maximum is 8 x 32768, so no overflow is possible.
- moved is computed in DONE by a full 64-bit compare against the latched board.

Optional Feature:
- Macro WIN_DETECT_EN.
- Defined: extra output port `win` (1 bit). It is set in DONE when any merge in the move produced a value >= WIN_LOG2, is held with board_out, and resets to 0.
- Undefined: the port is absent, and no comparator or sticky flag is built.

Decomposition:
- Shared package `game_pkg`:
  - constants TILE_W=4, N_BOXES=16, SCORE_W=19;
  - direction enum DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT;
  - FSM state enum;
  - the packing helpers for box index to bit slice.
- Sub-module `line_compact`: combinational. Takes a 4x4-bit line and produces the output line, the line's score contribution (17 bits), and a max-merged-value output for the win check.
  - Instantiated once and reused across the four LINE cycles.

Test Plan:
- Left on row 1 = [1,1,2,0], rest empty -> row 1 = [2,2,0,0], score_inc = 4, moved = 1, done at cycle 5.
- Left on row 1 = [2,2,2,2] -> [3,3,0,0], score_inc = 16. Right on row 1 = [1,0,0,1] -> [0,0,0,2], score_inc = 4.
- Up on column 1 = [15,15,0,0] (box1, box5) -> box1 = 15, box5 = 0, score_inc = 32768; with WIN_DETECT_EN, win = 1.
- Board 0x1234_2341_3412_4123, any direction -> board_out equals input, moved = 0, score_inc = 0.
- Pulse start again at cycle 2 with a different board -> ignored, result matches the first board. Assert resetn = 0 at cycle 3 -> no done, all outputs 0. After release, start -> a normal move completes in 5 cycles.
